// File: rtl/gcd_share_arbiter.sv
// gcd_share_arbiter: round-robin front end that shares one subtractive GCD core
// between NUM_REQ requesters. It latches the winner's operands and runs the core's
// four-phase go/done handshake. Zero operands are answered locally, because the
// core never terminates on a zero. Each result is returned with a one-cycle ack.
module gcd_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WIDTH-1:0]    x_in,
    input  logic [NUM_REQ*WIDTH-1:0]    y_in,
    output logic [NUM_REQ-1:0]          ack,
    output logic [WIDTH-1:0]            result,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        core_go,
    output logic [WIDTH-1:0]            core_x,
    output logic [WIDTH-1:0]            core_y,
    input  logic                        core_done,
    input  logic [WIDTH-1:0]            core_result
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   w_winner;
    logic             w_found;
    logic             w_zero;
    logic [WIDTH-1:0] w_sel_x;
    logic [WIDTH-1:0] w_sel_y;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_core_x;
    logic [WIDTH-1:0] r_core_y;

    // Round-robin pick: first set req bit at or above the pointer, wrapping around
    always_comb begin
        int             v_idx;
        logic [IDW-1:0] v_id;
        w_winner = r_ptr;
        w_found  = 1'b0;
        v_idx    = 0;
        v_id     = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx    = (int'(r_ptr) + k) % NUM_REQ;
            v_id     = IDW'(v_idx);
            w_winner = (!w_found && req[v_id]) ? v_id : w_winner;
            w_found  = w_found | req[v_id];
        end
    end

    // Operand slices of the current winner and zero-operand detection
    always_comb begin
        w_sel_x = x_in[w_winner*WIDTH +: WIDTH];
        w_sel_y = y_in[w_winner*WIDTH +: WIDTH];
        w_zero  = (w_sel_x == {WIDTH{1'b0}}) || (w_sel_y == {WIDTH{1'b0}});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic for the grant / core handshake / respond sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (w_zero) begin
                        w_next = S_RESPOND;
                    end else begin
                        w_next = S_RUN;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (core_done) begin
                    w_next = S_RELEASE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RELEASE: begin
                if (core_done) begin
                    w_next = S_RELEASE;
                end else begin
                    w_next = S_RESPOND;
                end
            end
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Grant, operand latch, result capture and pointer advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= {IDW{1'b0}};
            r_grant  <= {IDW{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_core_x <= {WIDTH{1'b0}};
            r_core_y <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_winner;
                        r_core_x <= w_sel_x;
                        r_core_y <= w_sel_y;
                        if (w_zero) begin
                            // gcd(0,a)=a and gcd(0,0)=0: pick whichever operand is non-zero
                            r_result <= (w_sel_x == {WIDTH{1'b0}}) ? w_sel_y : w_sel_x;
                        end
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        r_result <= core_result;
                    end
                end
                S_RESPOND: begin
                    r_ptr <= (r_grant == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : (r_grant + {{(IDW-1){1'b0}}, 1'b1});
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the state register only, so there is no path from req or core_done
    always_comb begin
        ack     = {NUM_REQ{1'b0}};
        core_go = (r_state == S_RUN);
        busy    = (r_state != S_IDLE);
        if (r_state == S_RESPOND) begin
            ack[r_grant] = 1'b1;
        end else begin
            ack = {NUM_REQ{1'b0}};
        end
    end

    assign result   = r_result;
    assign grant_id = r_grant;
    assign core_x   = r_core_x;
    assign core_y   = r_core_y;

endmodule

// File: doc/gcd_share_arbiter.md
Name: gcd_share_arbiter

Overview:
- Shares one gcd_fsm-controlled GCD core between NUM_REQ requesters.
- Arbitrates round-robin among requesters and latches the winner's operands.
- Sequences the core's go/done four-phase handshake, then returns the result with a one-cycle ack.
- Zero operands are resolved locally because the subtractive core never terminates on a zero operand.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  NUM_REQ  per-requester request level.
- x_in  input  NUM_REQ*WIDTH  operand x, requester i at bits [i*WIDTH +: WIDTH].
- y_in  input  NUM_REQ*WIDTH  operand y, same packing.
- ack  output  NUM_REQ  one-hot, one-cycle completion strobe.
- result  output  WIDTH  GCD of the served request; valid while ack≠0, held until next update.
- grant_id  output  $clog2(NUM_REQ)  index of the requester currently or last served.
- busy  output  1  high whenever state≠S_IDLE.
- core_go  output  1  go to the GCD core.
- core_x  output  WIDTH  latched x to the core.
- core_y  output  WIDTH  latched y to the core.
- core_done  input  1  done from the GCD core.
- core_result  input  WIDTH  GCD core output value.

Behaviour:
- Reset values:
  - State: S_IDLE.
  - Outputs: ack=0, result=0, grant_id=0, busy=0, core_go=0, core_x=0, core_y=0.
  - Round-robin pointer: 0.
- States: S_IDLE, S_RUN, S_RELEASE, S_RESPOND.
- S_IDLE:
  - If req==0, stay.
  - Otherwise the winner g is the first set bit of req scanning from the pointer upward, wrapping modulo NUM_REQ.
  - Register grant_id=g and core_x/core_y from the operand slices of requester g.
  - If either operand of g is 0: result := other operand (0 if both are 0), next state S_RESPOND.
  - Otherwise next state S_RUN.
- S_RUN:
  - core_go=1.
  - When core_done=1: result := core_result, next state S_RELEASE. Otherwise stay.
- S_RELEASE:
  - core_go=0.
  - Stay while core_done=1; when core_done=0, next state S_RESPOND.
- S_RESPOND:
  - ack[grant_id]=1 for exactly this cycle; all other ack bits are 0.
  - Pointer := (grant_id+1) mod NUM_REQ.
  - Next state S_IDLE.
- Output timing:
  - core_go, ack and busy are decoded from the state register only; there is no combinational path from req or core_done.
  - core_x/core_y stay stable from grant until the next grant.
- Requester contract:
  - Operands must be valid in the cycle req rises.
  - Operands may change after grant.
  - The requester deasserts req on the clock edge at which it samples ack=1; a req still high in the following S_IDLE cycle counts as a new request.
- Core interaction rules:
  - core_done observed outside S_RUN/S_RELEASE is ignored.
  - Deasserting req after grant does not abort the transaction; the result is still delivered with ack.
- Latency with the standard core:
  - x=y, req seen in S_IDLE at cycle 0: S_RUN cycles 1–4 (core IDLE, LOAD, COMPARE, DONE), S_RELEASE cycles 5–6, ack at cycle 7.
  - Zero-operand bypass: ack at cycle 1, core_go never asserted.
- Reset mid-operation: immediately returns to S_IDLE with all reset values; no ack is issued; the core shares rst and returns to its idle state.
- No starvation: any request held high is served within NUM_REQ transactions.

Test Plan:
1. req=0001, x0=12, y0=18 → core_go high until core_done; ack=0001 for one cycle; result=6; grant_id=0; busy low afterwards.
2. req=0100, x2=y2=7 → ack[2] exactly 7 cycles after the req sample; result=7; core_go high for 4 cycles.
3. Bypass cases: req=0010, x1=0, y1=9 → ack[1] next cycle, result=9, core_go stays 0. Repeat with x1=5, y1=0 → result=5. Repeat with x1=y1=0 → result=0.
4. All four req high with operands (8,12), (9,6), (14,21), (5,3) → acks in order 0,1,2,3 with results 4, 3, 7, 1; each requester drops req on its ack.
5. req[1] and req[3] held continuously → grants alternate 1,3,1,3; no other ack bit is ever set.
6. Assert rst during S_RUN → core_go=0, ack=0, busy=0 in the same cycle. After release, req=1000 is granted first because the pointer is reset to 0 and only requester 3 is requesting.
